// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller: state encodings,
// opcode/funct values and the ALU control encoding used by the ALU and the
// single-cycle decoder.
package mips_pkg;

  // Controller states, numbered so state_o can be read directly on a debugger.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11,
    S_JR     = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  // ALU control encodings
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;
  localparam logic [2:0] ALU_SRA = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU A-input and B-input, PC source selects
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_REG   = 2'b01;
  localparam logic [1:0] SRCA_SHAMT = 2'b10;
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BRIMM = 2'b11;
  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_OUT  = 2'b01;
  localparam logic [1:0] PCSRC_JMP  = 2'b10;
  localparam logic [1:0] PCSRC_REGA = 2'b11;

endpackage

// File: rtl/mc_alu_decoder.sv
// Maps an R-type funct field onto the ALU control encoding. is_shift_imm
// marks the shamt-operand shifts; funct_valid is low for anything that is not
// an ALU operation (jr included, the controller routes that separately).
module mc_alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       is_shift_imm,
  output logic       funct_valid
);

  // Pure lookup from funct to ALU operation
  always_comb begin
    alu_control  = ALU_ADD;
    is_shift_imm = 1'b0;
    funct_valid  = 1'b1;
    case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_SUB:  alu_control = ALU_SUB;
      FN_AND:  alu_control = ALU_AND;
      FN_OR:   alu_control = ALU_OR;
      FN_SLT:  alu_control = ALU_SLT;
      FN_SLL:  begin alu_control = ALU_SLL; is_shift_imm = 1'b1; end
      FN_SRL:  begin alu_control = ALU_SRL; is_shift_imm = 1'b1; end
      FN_SRA:  begin alu_control = ALU_SRA; is_shift_imm = 1'b1; end
      FN_SLLV: alu_control = ALU_SLL;
      FN_SRLV: alu_control = ALU_SRL;
      FN_SRAV: alu_control = ALU_SRA;
      default: funct_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencer for the multicycle MIPS datapath. Each instruction walks
// fetch/decode/execute/memory/writeback; memory states stall on mem_ready.
// Write enables are gated with rst_n so nothing is written once reset falls.
module multicycle_controller
  import mips_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_re,
  output logic       mem_we,
  output logic       ir_we,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       imm_zext,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_control,
  output logic [3:0] state_o,
  output logic       illegal_op
);

  state_t     state_reg;
  state_t     state_next;
  logic [2:0] rexec_alu;
  logic       rexec_shift_imm;
  logic       funct_valid;
  logic       pc_en_raw;
  logic       mem_re_raw;
  logic       mem_we_raw;
  logic       ir_we_raw;
  logic       reg_we_raw;
  logic       illegal_raw;

  mc_alu_decoder u_alu_decoder (
    .funct        (funct),
    .alu_control  (rexec_alu),
    .is_shift_imm (rexec_shift_imm),
    .funct_valid  (funct_valid)
  );

  // State register, asynchronously returned to fetch on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= RESET_STATE;
    else        state_reg <= state_next;
  end

  // Next-state sequencing and opcode dispatch
  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:            state_next = S_MEMADR;
          OP_RTYPE: begin
            if (funct == FN_JR)    state_next = S_JR;
            else if (funct_valid)  state_next = S_REXEC;
            else                   state_next = S_TRAP;
          end
          OP_BEQ, OP_BNE:          state_next = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI: state_next = S_IEXEC;
          OP_J:                    state_next = S_JUMP;
          default:                 state_next = S_TRAP;
        endcase
      end
      S_MEMADR: state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_next = mem_ready ? S_FETCH : S_MEMWR;
      S_REXEC:  state_next = S_ALUWB;
      S_IEXEC:  state_next = S_IWB;
      default:  state_next = S_FETCH;
    endcase
  end

  // Datapath controls decoded from the current state
  always_comb begin
    pc_en_raw   = 1'b0;
    mem_re_raw  = 1'b0;
    mem_we_raw  = 1'b0;
    ir_we_raw   = 1'b0;
    reg_we_raw  = 1'b0;
    illegal_raw = 1'b0;
    iord        = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    imm_zext    = 1'b0;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_REG;
    pc_src      = PCSRC_ALU;
    alu_control = ALU_ADD;
    case (state_reg)
      S_FETCH: begin
        mem_re_raw = 1'b1;
        alu_src_b  = SRCB_FOUR;
        ir_we_raw  = mem_ready;
        pc_en_raw  = mem_ready;
      end
      S_DECODE: alu_src_b = SRCB_BRIMM;
      S_MEMADR: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        iord       = 1'b1;
        mem_re_raw = 1'b1;
      end
      S_MEMWB: begin
        reg_we_raw = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        mem_we_raw = 1'b1;
      end
      S_REXEC: begin
        alu_src_a   = rexec_shift_imm ? SRCA_SHAMT : SRCA_REG;
        alu_control = rexec_alu;
      end
      S_ALUWB: begin
        reg_we_raw = 1'b1;
        reg_dst    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = SRCA_REG;
        alu_control = ALU_SUB;
        pc_src      = PCSRC_OUT;
        pc_en_raw   = (opcode == OP_BNE) ? ~zero : zero;
      end
      S_IEXEC: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
        case (opcode)
          OP_ANDI: begin alu_control = ALU_AND; imm_zext = 1'b1; end
          OP_ORI:  begin alu_control = ALU_OR;  imm_zext = 1'b1; end
          default: alu_control = ALU_ADD;
        endcase
      end
      S_IWB:  reg_we_raw = 1'b1;
      S_JUMP: begin
        pc_src    = PCSRC_JMP;
        pc_en_raw = 1'b1;
      end
      S_JR: begin
        pc_src    = PCSRC_REGA;
        pc_en_raw = 1'b1;
      end
      S_TRAP: illegal_raw = 1'b1;
      // Unreachable encodings drive everything low and fall back to fetch
      default: alu_control = 3'b000;
    endcase
  end

  // Strobes are killed the moment reset falls, even before the state updates
  assign pc_en      = pc_en_raw   & rst_n;
  assign mem_re     = mem_re_raw  & rst_n;
  assign mem_we     = mem_we_raw  & rst_n;
  assign ir_we      = ir_we_raw   & rst_n;
  assign reg_we     = reg_we_raw  & rst_n;
  assign illegal_op = illegal_raw & rst_n;
  assign state_o    = state_reg;

endmodule
